mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder serving the multi-cycle controller's level-held request bus (en/ren/wen/addr/din).
- Returns read data after a programmable latency and flags completion with a one-cycle ack.
- Holds read data stable until the request is withdrawn or changed, so the controller's fixed wait states and the SINK/infer readout path both see stable dout.
- Owns a 32-bit word array; it is the slave end of the controller's memory interface.

Parameters:
- DEPTH, 8192, number of 32-bit words; legal word addresses are 0..DEPTH-1.
- ADDR_W, 16, request address width; addresses are word indices.
- READ_LAT, 2, cycles from read acceptance to dout valid; legal range 1..7.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- en  in  1  request enable, held high by the initiator for the request's duration.
- ren  in  1  read strobe; qualified by en.
- wen  in  1  write strobe; qualified by en.
- addr  in  ADDR_W  word address.
- din  in  32  write data.
- dout  out  32  read data; registered.
- ack  out  1  one-cycle pulse when a request completes.
- busy  out  1  high while a read is in flight (READ state).
- err  out  1  one-cycle pulse on an out-of-range access or on ren&wen both high.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, dout=0, ack=0, busy=0, err=0, latched op/addr cleared. Array contents are not cleared.
- Reset mid-read aborts the read with no ack. Reset mid-write is harmless because a write commits in its acceptance cycle.
- State IDLE:
  - en&wen (wen has priority over ren): if addr<DEPTH, mem[addr]<=din; ack=1 next cycle; latch {op=W, addr}; go HOLD.
  - en&ren&!wen: latch {op=R, addr}; load counter=READ_LAT-1; busy=1; go READ.
  - en with neither strobe: stay IDLE, no ack.
- State READ: counter decrements each cycle. At counter==0, dout<=mem[latched addr] (or 0 if out of range); ack=1 for one cycle; busy=0; go HOLD.
  - Total latency: ack and dout are visible exactly READ_LAT cycles after the accepting edge.
  - Input changes during READ are ignored; the latched request completes.
- State HOLD: dout holds its value; no ack.
  - en==0 -> IDLE.
  - en==1 with a different op or addr than latched -> handled as a new request in the same cycle, with the same actions as IDLE.
  - Same op and addr -> stay in HOLD, no repeat write and no repeat ack. A held write is committed exactly once.
- err rules:
  - Pulses with the ack of any access where addr>=DEPTH. Such reads return 0 and such writes are dropped.
  - Also pulses in the acceptance cycle when en&ren&wen.
- dout changes only on read completion or reset. Writes never alter dout, even to the address last read.
- Back-to-back reads to different addresses without en dropping are each accepted from HOLD and each ack once.

Optional Feature:
- Macro MEM_STATS_EN.
- When defined, adds outputs rd_count[31:0] and wr_count[31:0]:
  - rd_count increments on each read ack; wr_count increments on each write ack.
  - Out-of-range accesses are counted as well.
  - Both wrap at 2^32 and are cleared by reset.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write then read: reset low 2 cycles, then en=1 wen=1 addr=5 din=0xDEADBEEF for 1 cycle, drop en, then en=1 ren=1 addr=5 -> ack one cycle after write acceptance; dout=0xDEADBEEF with ack exactly 2 cycles after read acceptance (READ_LAT=2); busy high for those 2 cycles.
- Held request: en/ren held 10 cycles at addr=5 -> exactly one ack; dout stable for all 10 cycles. en/wen held 6 cycles -> one write, one ack.
- Request change while held: en=1 ren=1, addr 5 then 6 without dropping en -> two acks; dout=mem[6] after the second; addr change during READ is ignored.
- Boundaries: read addr=8191 returns the stored word with err=0; addr=8192 -> dout=0 with ack and err pulsing together; write to 9000 leaves the array unchanged; ren&wen at addr=3 -> err pulse, write performed.
- Reset mid-read: assert reset on the cycle after read acceptance -> no ack, dout=0, busy=0, state IDLE; a subsequent read to the same address returns the pre-reset stored data.
- With MEM_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2; reset -> both 0.

Source files
------------

// File: rtl/mem_responder.sv
// Word-array memory slave for a level-held en/ren/wen request bus. Reads complete READ_LAT cycles after acceptance.
// Define MEM_STATS_EN to add the rd_count/wr_count access counters.
module mem_responder #(
    parameter int DEPTH    = 8192,
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              ren,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              ack,
    output logic              busy,
`ifdef MEM_STATS_EN
    output logic              err,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`else
    output logic              err
`endif
);

    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [2:0]  LAT_M1  = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_HOLD
    } state_t;

    typedef enum logic {
        OP_R,
        OP_W
    } op_t;

    state_t state_q, state_d;
    op_t    op_q, op_d, req_op;

    logic [ADDR_W-1:0] laddr_q, laddr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [31:0]       dout_q;

    logic start;
    logic rd_fire;
    logic wr_acc;
    logic mem_we;
    logic addr_oob;
    logic laddr_oob;

    logic [31:0] mem [DEPTH];

    assign addr_oob  = (32'(addr) >= DEPTH_U);
    assign laddr_oob = (32'(laddr_q) >= DEPTH_U);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        laddr_d = laddr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        start   = 1'b0;
        rd_fire = 1'b0;
        wr_acc  = 1'b0;
        req_op  = wen ? OP_W : OP_R;

        case (state_q)
            S_IDLE: start = en;
            S_READ: begin
                // Inputs are ignored here; the latched request always completes.
                if (cnt_q == 3'd0) begin
                    rd_fire = 1'b1;
                    ack_d   = 1'b1;
                    err_d   = laddr_oob;
                    busy_d  = 1'b0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_HOLD: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (!(ren || wen) || (req_op != op_q) || (addr != laddr_q)) begin
                    start = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Request acceptance is shared by IDLE and a changed request seen in HOLD.
        if (start) begin
            if (wen) begin
                wr_acc  = 1'b1;
                ack_d   = 1'b1;
                err_d   = addr_oob | ren;
                op_d    = OP_W;
                laddr_d = addr;
                state_d = S_HOLD;
            end else if (ren) begin
                op_d    = OP_R;
                laddr_d = addr;
                cnt_d   = LAT_M1;
                busy_d  = 1'b1;
                state_d = S_READ;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    assign mem_we = wr_acc & ~addr_oob & reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_R;
            laddr_q <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            laddr_q <= laddr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr[IDX_W-1:0]] <= din;
        end
    end

    // Registered read port; it only loads on read completion, so writes never disturb dout.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dout_q <= '0;
        end else if (rd_fire) begin
            dout_q <= laddr_oob ? 32'd0 : mem[laddr_q[IDX_W-1:0]];
        end
    end

    assign dout = dout_q;
    assign ack  = ack_q;
    assign busy = busy_q;
    assign err  = err_q;

`ifdef MEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q + (rd_fire ? 32'd1 : 32'd0);
        wr_count_d = wr_count_q + (wr_acc ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: issued requests push expected acks, a negedge monitor pops and compares.
module tb_mem_responder;
    localparam int DEPTH    = 8192;
    localparam int ADDR_W   = 16;
    localparam int READ_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              en, ren, wen;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din, dout;
    logic              ack, busy, err;
`ifdef MEM_STATS_EN
    logic [31:0]       rd_count, wr_count;
`endif

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .ren      (ren),
        .wen      (wen),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .ack      (ack),
        .busy     (busy),
`ifdef MEM_STATS_EN
        .err      (err),
        .rd_count (rd_count),
        .wr_count (wr_count)
`else
        .err      (err)
`endif
    );

    typedef struct {
        int unsigned cyc;
        bit          is_rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_dout = 32'd0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          running = 0;
    bit          en_held = 0;
    bit          last_w = 0;
    int          last_a = 0;
    int unsigned n_rd = 0;
    int unsigned n_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expectation, in the right cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   busy_exp;
        if (running && reset) begin
            if (ack) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack at cycle %0d: got ack=1 expected no ack", cyc);
                end else begin
                    e = q.pop_front();
                    check32("ack_cycle", cyc, e.cyc);
                    check32("ack_err", {31'b0, err}, {31'b0, e.err});
                    if (e.is_rd) begin
                        check32("rd_data", dout, e.data);
                        model_dout = e.data;
                        n_rd++;
                    end else begin
                        n_wr++;
                    end
                    $display("ack cyc=%0d %s dout=%h err=%b", cyc, e.is_rd ? "RD" : "WR", dout, err);
                end
            end else begin
                check32("err_without_ack", {31'b0, err}, 32'd0);
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_missing at cycle %0d: got no ack expected ack at cycle %0d", cyc, q[0].cyc);
                    void'(q.pop_front());
                end
            end
            check32("dout_hold", dout, model_dout);
            busy_exp = 0;
            foreach (q[i]) begin
                if (q[i].is_rd && q[i].cyc > cyc && (q[i].cyc - cyc) <= READ_LAT) busy_exp = 1;
            end
            check32("busy", {31'b0, busy}, {31'b0, busy_exp});
        end
    end

    task automatic push_rd(input int a, input int unsigned at);
        exp_t e;
        e.cyc   = at;
        e.is_rd = 1;
        e.err   = (a >= DEPTH);
        e.data  = 32'd0;
        if (a < DEPTH) e.data = model_mem[a];
        q.push_back(e);
    endtask

    // Called #1 after a posedge; holds the request for 'hold' edges.
    task automatic issue(input bit r, input bit w, input int a, input logic [31:0] d, input int hold);
        bit   acc;
        exp_t e;
        acc  = !en_held || (w != last_w) || (a != last_a);
        en   = 1'b1;
        ren  = r;
        wen  = w;
        addr = 16'(a);
        din  = d;
        if (acc) begin
            if (w) begin
                e.cyc   = cyc + 1;
                e.is_rd = 0;
                e.err   = (a >= DEPTH) || r;
                e.data  = 32'd0;
                if (a < DEPTH) model_mem[a] = d;
                q.push_back(e);
            end else begin
                push_rd(a, cyc + 1 + READ_LAT);
            end
        end
        en_held = 1;
        last_w  = w;
        last_a  = a;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic drop();
        en  = 1'b0;
        ren = 1'b0;
        wen = 1'b0;
        @(posedge clk);
        #1;
        en_held = 0;
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        ren   = 1'b0;
        wen   = 1'b0;
        addr  = '0;
        din   = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check32("reset_dout", dout, 32'd0);
        check32("reset_ack", {31'b0, ack}, 32'd0);
        check32("reset_busy", {31'b0, busy}, 32'd0);
        check32("reset_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        running = 1;

        // Write then read, held read, held write.
        issue(0, 1, 5, 32'hDEADBEEF, 1);
        drop();
        issue(1, 0, 5, 32'd0, 10);
        drop();
        issue(0, 1, 9, 32'h1234_5678, 6);
        drop();

        // Prefill the pool used by the random phase, back to back from HOLD.
        for (int i = 0; i < 32; i++) issue(0, 1, i, $urandom, 1);
        issue(0, 1, 8191, $urandom, 1);
        issue(0, 1, 808, $urandom, 1);
        drop();

        // Address change mid-read is ignored, then accepted as a new read from HOLD.
        en  = 1'b1;
        ren = 1'b1;
        wen = 1'b0;
        addr = 16'd5;
        push_rd(5, cyc + 1 + READ_LAT);
        @(posedge clk);
        #1;
        addr = 16'd6;
        push_rd(6, cyc + 2 * READ_LAT + 1);
        repeat (2 * READ_LAT + 1) @(posedge clk);
        #1;
        en_held = 1;
        last_w  = 0;
        last_a  = 6;
        drop();

        // Boundaries.
        issue(1, 0, 8191, 32'd0, READ_LAT + 1);
        issue(1, 0, 8192, 32'd0, READ_LAT + 1);
        drop();
        issue(0, 1, 9000, 32'hBAD0_0BAD, 1);
        drop();
        issue(1, 0, 808, 32'd0, READ_LAT + 1);
        drop();
        issue(1, 1, 3, 32'hC0FF_EE03, 1);
        drop();
        issue(1, 0, 3, 32'd0, READ_LAT + 1);
        drop();

        // Reset one cycle after read acceptance aborts the read.
        issue(1, 0, 7, 32'd0, 1);
        reset = 1'b0;
        en    = 1'b0;
        ren   = 1'b0;
        q.delete();
        model_dout = 32'd0;
        en_held = 0;
        n_rd = 0;
        n_wr = 0;
        @(posedge clk);
        @(negedge clk);
        check32("rst_mid_dout", dout, 32'd0);
        check32("rst_mid_busy", {31'b0, busy}, 32'd0);
        check32("rst_mid_ack", {31'b0, ack}, 32'd0);
`ifdef MEM_STATS_EN
        check32("rst_rd_count", rd_count, 32'd0);
        check32("rst_wr_count", wr_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(1, 0, 7, 32'd0, READ_LAT + 1);
        drop();

        // Random phase over the prefilled pool plus out-of-range addresses.
        for (int t = 0; t < 250; t++) begin
            int kind;
            int sel;
            int a;
            bit r;
            bit w;
            kind = $urandom_range(0, 9);
            r = (kind < 5) || (kind == 9);
            w = (kind >= 5);
            sel = $urandom_range(0, 19);
            if (sel < 16) a = $urandom_range(0, 31);
            else if (sel == 16) a = 8191;
            else if (sel < 19) a = 8192 + $urandom_range(0, 900);
            else a = 65535;
            if (r && !w) issue(r, w, a, $urandom, READ_LAT + 1 + $urandom_range(0, 3));
            else issue(r, w, a, $urandom, 1 + $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) drop();
        end

        drop();
        repeat (READ_LAT + 4) @(posedge clk);
        #1;
        check32("drain_outstanding", q.size(), 32'd0);
`ifdef MEM_STATS_EN
        check32("rd_count", rd_count, n_rd);
        check32("wr_count", wr_count, n_wr);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
